// File: rtl/vga_timing_gen_pkg.sv
// Shared 640x480 timing defaults and types for the VGA timing generator.
// Coordinates are 11-bit unsigned; sync bundle is a packed struct.
package vga_timing_gen_pkg;

  localparam int H_VISIBLE_D = 640;
  localparam int H_FRONT_D   = 16;
  localparam int H_SYNC_D    = 96;
  localparam int H_BACK_D    = 48;
  localparam int V_VISIBLE_D = 480;
  localparam int V_FRONT_D   = 10;
  localparam int V_SYNC_D    = 2;
  localparam int V_BACK_D    = 33;
  localparam int PIPE_LAT_D  = 1;
  localparam int COORD_W     = 11;
  localparam int COORD_MAX   = 2047;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic hsync_n;
    logic vsync_n;
    logic blank_n;
  } sync_t;

  localparam sync_t SYNC_RST = '{
    hsync_n: 1'b1,
    vsync_n: 1'b1,
    blank_n: 1'b0
  };

  function automatic logic in_span(
    input coord_t v,
    input int     lo,
    input int     hi
  );
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Fixed-depth shift register aligning sync/blank with the draw pipeline.
// Depth 0 degenerates to a wire.
module sync_delay_line #(
  parameter int           W       = 3,
  parameter int           DEPTH   = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_thru
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ reset;
      assign q = d;
    end else begin : g_pipe
      logic [W-1:0] stg [DEPTH];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) begin
            stg[i] <= RST_VAL;
          end
        end else begin
          stg[0] <= d;
          for (int i = 1; i < DEPTH; i++) begin
            stg[i] <= stg[i-1];
          end
        end
      end

      assign q = stg[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel strobe, stage-0 x/y counters, frame pulses,
// and sync/blank delayed to match the downstream draw latency.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_D,
  parameter int H_FRONT   = H_FRONT_D,
  parameter int H_SYNC    = H_SYNC_D,
  parameter int H_BACK    = H_BACK_D,
  parameter int V_VISIBLE = V_VISIBLE_D,
  parameter int V_FRONT   = V_FRONT_D,
  parameter int V_SYNC    = V_SYNC_D,
  parameter int V_BACK    = V_BACK_D,
  parameter int PIPE_LAT  = PIPE_LAT_D
) (
  input  logic        clk,
  input  logic        reset,
  output logic        pix_en,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        blank_n,
  output logic        frame_start,
  output logic        vblank_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_BEG  = H_VISIBLE + H_FRONT;
  localparam int HS_END  = HS_BEG + H_SYNC - 1;
  localparam int VS_BEG  = V_VISIBLE + V_FRONT;
  localparam int VS_END  = VS_BEG + V_SYNC - 1;

  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS  = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS  = coord_t'(V_VISIBLE);

  generate
    if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX) begin : g_bad_total
      $error("vga_timing_gen: H/V totals exceed 11-bit range");
    end
    if (PIPE_LAT < 0 || PIPE_LAT > 4) begin : g_bad_lat
      $error("vga_timing_gen: PIPE_LAT outside 0..4");
    end
  endgenerate

  logic   div;
  coord_t x_q;
  coord_t y_q;
  sync_t  raw;
  sync_t  dly;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= 1'b0;
      x_q <= '0;
      y_q <= '0;
    end else begin
      div <= ~div;
      if (div) begin
        if (x_q == H_LAST) begin
          x_q <= '0;
          y_q <= (y_q == V_LAST) ? '0 : y_q + coord_t'(1);
        end else begin
          x_q <= x_q + coord_t'(1);
        end
      end
    end
  end

  always_comb begin
    raw         = SYNC_RST;
    raw.hsync_n = !in_span(x_q, HS_BEG, HS_END);
    raw.vsync_n = !in_span(y_q, VS_BEG, VS_END);
    raw.blank_n = (x_q < H_VIS) && (y_q < V_VIS);
  end

  sync_delay_line #(
    .W       ($bits(sync_t)),
    .DEPTH   (PIPE_LAT),
    .RST_VAL (SYNC_RST)
  ) u_dly (
    .clk   (clk),
    .reset (reset),
    .d     (raw),
    .q     (dly)
  );

  // Pulses are stage-0 so the game logic sees them with the coordinates.
  assign pix_en       = div;
  assign x            = x_q;
  assign y            = y_q;
  assign frame_start  = div && (x_q == '0) && (y_q == '0);
  assign vblank_start = div && (x_q == '0) && (y_q == V_VIS);
  assign hsync_n      = dly.hsync_n;
  assign vsync_n      = dly.vsync_n;
  assign blank_n      = dly.blank_n;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: two reduced-size instances (latency 3 and 0)
// against a reference model, plus a default 640x480 instance.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  logic        pe_a, hs_a, vs_a, bl_a, fs_a, vbs_a;
  logic [10:0] x_a, y_a;
  logic        pe_b, hs_b, vs_b, bl_b, fs_b, vbs_b;
  logic [10:0] x_b, y_b;
  logic        pe_d, hs_d, vs_d, bl_d, fs_d, vbs_d;
  logic [10:0] x_d, y_d;

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .PIPE_LAT(3)
  ) dut_a (
    .clk(clk), .reset(reset), .pix_en(pe_a), .x(x_a), .y(y_a),
    .hsync_n(hs_a), .vsync_n(vs_a), .blank_n(bl_a),
    .frame_start(fs_a), .vblank_start(vbs_a)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .PIPE_LAT(0)
  ) dut_b (
    .clk(clk), .reset(reset), .pix_en(pe_b), .x(x_b), .y(y_b),
    .hsync_n(hs_b), .vsync_n(vs_b), .blank_n(bl_b),
    .frame_start(fs_b), .vblank_start(vbs_b)
  );

  vga_timing_gen dut_d (
    .clk(clk), .reset(reset), .pix_en(pe_d), .x(x_d), .y(y_d),
    .hsync_n(hs_d), .vsync_n(vs_d), .blank_n(bl_d),
    .frame_start(fs_d), .vblank_start(vbs_d)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int   m_x = 0;
  int   m_y = 0;
  logic m_div = 1'b0;
  logic [2:0] q3[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic logic [2:0] raw_s(input int xx, input int yy);
    logic hs, vs, bl;
    hs = !(xx >= 10 && xx <= 12);
    vs = !(yy >= 5 && yy <= 6);
    bl = (xx < 8) && (yy < 4);
    return {hs, vs, bl};
  endfunction

  task automatic model_reset();
    m_div = 1'b0;
    m_x   = 0;
    m_y   = 0;
    q3    = '{3'b110, 3'b110, 3'b110};
  endtask

  task automatic cmp();
    chk("a_x", 32'(x_a), 32'(m_x));
    chk("a_y", 32'(y_a), 32'(m_y));
    chk("a_pix", 32'(pe_a), 32'(m_div));
    chk("a_fs", 32'(fs_a), 32'(m_div && m_x == 0 && m_y == 0));
    chk("a_vbs", 32'(vbs_a), 32'(m_div && m_x == 0 && m_y == 4));
    chk("a_sync", 32'({hs_a, vs_a, bl_a}), 32'(q3[2]));
    chk("b_x", 32'(x_b), 32'(m_x));
    chk("b_sync", 32'({hs_b, vs_b, bl_b}), 32'(raw_s(m_x, m_y)));
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      q3.push_front(raw_s(m_x, m_y));
      void'(q3.pop_back());
      if (m_div) begin
        if (m_x == 15) begin
          m_x = 0;
          m_y = (m_y == 8) ? 0 : m_y + 1;
        end else begin
          m_x++;
        end
      end
      m_div = !m_div;
    end
    cyc++;
    @(negedge clk);
    cmp();
  endtask

  initial begin
    int d_pe, fs_cnt, bl_cnt, vb_cnt, max_x, max_y;
    int t656, t_fall, t_rise;
    logic [10:0] d_px;
    logic d_phs;
    logic found;

    d_pe = 0; fs_cnt = 0; bl_cnt = 0; vb_cnt = 0;
    max_x = 0; max_y = 0;
    t656 = -1; t_fall = -1; t_rise = -1;
    d_px = '0; d_phs = 1'b1; found = 1'b0;

    reset = 1'b1;
    model_reset();
    tick();
    tick();
    chk("d_rst_x", 32'(x_d), 32'd0);
    chk("d_rst_sync", 32'({hs_d, vs_d, bl_d}), 32'(3'b110));
    chk("d_rst_pix", 32'(pe_d), 32'd0);

    reset = 1'b0;
    cyc   = 0;
    for (int i = 0; i < 1600; i++) begin
      tick();
      if (pe_d) d_pe++;
      if (x_d == 11'd656 && d_px == 11'd655) t656 = cyc;
      if (!hs_d && d_phs) t_fall = cyc;
      if (hs_d && !d_phs) t_rise = cyc;
      d_px  = x_d;
      d_phs = hs_d;
      if (fs_a) fs_cnt++;
      if (i < 288) begin
        bl_cnt += int'(bl_b);
        vb_cnt += int'(vbs_b);
      end
      if (int'(x_a) > max_x) max_x = int'(x_a);
      if (int'(y_a) > max_y) max_y = int'(y_a);
    end

    chk("d_pix_count", 32'(d_pe), 32'd800);
    chk("d_line_x", 32'(x_d), 32'd0);
    chk("d_line_y", 32'(y_d), 32'd1);
    chk("d_hs_fall", 32'(t_fall), 32'(t656 + 1));
    chk("d_hs_fall_at", 32'(t_fall), 32'd1313);
    chk("d_hs_width", 32'(t_rise - t_fall), 32'd192);
    chk("a_frames", 32'(fs_cnt), 32'd6);
    chk("b_blank_frame", 32'(bl_cnt), 32'd64);
    chk("b_vblank_frame", 32'(vb_cnt), 32'd1);
    chk("a_max_x", 32'(max_x), 32'd15);
    chk("a_max_y", 32'(max_y), 32'd8);

    for (int i = 0; i < 300 && !found; i++) begin
      tick();
      found = (m_x == 5 && m_y == 2);
    end
    chk("reach_mid", 32'(found), 32'd1);

    #2;
    reset = 1'b1;
    #1;
    model_reset();
    cmp();
    chk("d_async_x", 32'(x_d), 32'd0);
    chk("d_async_sync", 32'({hs_d, vs_d, bl_d}), 32'(3'b110));
    chk("a_async_fs", 32'(fs_a), 32'd0);

    tick();
    tick();
    reset = 1'b0;
    cyc   = 0;
    tick();
    chk("a_first_pix", 32'(pe_a), 32'd1);
    chk("a_first_fs", 32'(fs_a), 32'd1);
    chk("d_first_fs", 32'({pe_d, fs_d}), 32'(2'b11));

    for (int i = 0; i < 600; i++) begin
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
